hazard_detection_unit: RTL and testbench

Pipeline stall/flush controller for the 5-stage MIPS core: the stalling counterpart of the forwarding logic. Detects hazards that bypassing cannot resolve (load-use, ID-stage branch operand dependencies, data-memory wait) and drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and a global pipeline hold. Sits in ID alongside the register file and branch comparator; its outputs gate the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/hazard_detection_unit.sv | 107 ++++++++++
 tb/tb_hazard_detection_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: ID-stage stall/flush/hold controller for the 5-stage MIPS pipeline.
// Define HAZARD_STAT_EN to add the StallCnt_o stall-cycle counter.
module hazard_detection_unit (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [4:0] IFIDRs_i,
    input  logic [4:0] IFIDRt_i,
    input  logic       IFIDUsesRt_i,
    input  logic       IFIDBranch_i,
    input  logic       IDEXMemRead_i,
    input  logic       IDEXRegWrite_i,
    input  logic [4:0] IDEXRd_i,
    input  logic       EXMEMMemRead_i,
    input  logic [4:0] EXMEMRd_i,
    input  logic       BranchTaken_i,
    input  logic       MemReq_i,
    input  logic       MemAck_i,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IFIDFlush_o,
    output logic       IDEXBubble_o,
    output logic       PipeHold_o
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0] StallCnt_o
`endif
);
    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

    state_t     state_q, state_d, ret_q, ret_d;
    logic [1:0] cnt_q, cnt_d;
    logic       mem_wait, load_use, alu_br, ld_mem_br, hazard, hold, stall;

    function automatic logic match(input logic [4:0] r);
        return r != 5'd0 && (r == IFIDRs_i || (IFIDUsesRt_i && r == IFIDRt_i));
    endfunction

    assign mem_wait  = MemReq_i && !MemAck_i;
    assign load_use  = IDEXMemRead_i && match(IDEXRd_i);
    assign alu_br    = IFIDBranch_i && IDEXRegWrite_i && !IDEXMemRead_i && match(IDEXRd_i);
    assign ld_mem_br = IFIDBranch_i && EXMEMMemRead_i && match(EXMEMRd_i);
    assign hazard    = load_use || alu_br || ld_mem_br;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    ret_d   = RUN;
                end else if (load_use && IFIDBranch_i) begin
                    state_d = STALL;
                    cnt_d   = 2'd1;
                end
            end
            STALL: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    ret_d   = STALL;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    state_d = (cnt_q <= 2'd1) ? RUN : STALL;
                end
            end
            MEM_WAIT: state_d = MemAck_i ? ret_q : MEM_WAIT;
            default:  state_d = RUN;
        endcase
    end

    // Reset forces the idle pattern so the pipeline keeps flowing while held in reset.
    always_comb begin
        hold  = rst_n_i && (state_q == MEM_WAIT || mem_wait);
        stall = rst_n_i && !hold && (state_q == STALL || (state_q == RUN && hazard));
        PipeHold_o   = hold;
        IDEXBubble_o = stall;
        PCWrite_o    = !(hold || stall);
        IFIDWrite_o  = !(hold || stall);
        IFIDFlush_o  = rst_n_i && state_q == RUN && !mem_wait && !hazard && BranchTaken_i;
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            stat_q <= 32'd0;
        else if (hold || stall)
            stat_q <= stat_q + 32'd1;
    end

    assign StallCnt_o = stat_q;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed and random checks against an owed-bubble reference model.
module tb_hazard_detection_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic       uses_rt, branch, ex_mr, ex_rw, mem_mr, taken, req, ack;
    logic       pc_w, ifid_w, flush, bubble, hold;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int          n_chk = 0, n_fail = 0;
    int          owed = 0;
    bit          waiting = 0;
    logic [31:0] stat = 0;

    always #5 clk = ~clk;

    hazard_detection_unit dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .IFIDRs_i(rs), .IFIDRt_i(rt), .IFIDUsesRt_i(uses_rt), .IFIDBranch_i(branch),
        .IDEXMemRead_i(ex_mr), .IDEXRegWrite_i(ex_rw), .IDEXRd_i(ex_rd),
        .EXMEMMemRead_i(mem_mr), .EXMEMRd_i(mem_rd),
        .BranchTaken_i(taken), .MemReq_i(req), .MemAck_i(ack),
        .PCWrite_o(pc_w), .IFIDWrite_o(ifid_w), .IFIDFlush_o(flush),
        .IDEXBubble_o(bubble), .PipeHold_o(hold)
`ifdef HAZARD_STAT_EN
        , .StallCnt_o(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit src(input logic [4:0] r);
        return r != 0 && (r == rs || (uses_rt && r == rt));
    endfunction

    // Bubbles the ID instruction must wait: the largest producer-to-consumer gap.
    function automatic int need();
        int ex_lat, mem_lat;
        ex_lat  = !src(ex_rd) ? 0 : ex_mr ? (branch ? 2 : 1) : (ex_rw && branch ? 1 : 0);
        mem_lat = (branch && mem_mr && src(mem_rd)) ? 1 : 0;
        return ex_lat > mem_lat ? ex_lat : mem_lat;
    endfunction

    task automatic step();
        bit e_fl, e_bb, e_hd, n_wait;
        int n_owed, nd;
        #1;
        e_fl = 0; e_bb = 0; e_hd = 0; n_owed = owed; n_wait = waiting;
        nd = need();
        if (!rst_n) begin
            n_owed = 0; n_wait = 0;
        end else if (waiting) begin
            e_hd = 1; n_wait = !ack;
        end else if (req && !ack) begin
            e_hd = 1; n_wait = 1;
        end else if (owed > 0) begin
            e_bb = 1; n_owed = owed - 1;
        end else if (nd > 0) begin
            e_bb = 1; n_owed = nd - 1;
        end else
            e_fl = taken;
        chk("pc_write", 32'(pc_w), 32'(!(e_bb || e_hd)));
        chk("ifid_write", 32'(ifid_w), 32'(!(e_bb || e_hd)));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("bubble", 32'(bubble), 32'(e_bb));
        chk("hold", 32'(hold), 32'(e_hd));
`ifdef HAZARD_STAT_EN
        chk("stall_cnt", stall_cnt, stat);
`endif
        @(posedge clk);
        owed = n_owed; waiting = n_wait;
        stat = !rst_n ? 32'd0 : (e_bb || e_hd) ? stat + 32'd1 : stat;
        #1;
    endtask

    task automatic idle_in();
        rst_n = 1; rs = 0; rt = 0; ex_rd = 0; mem_rd = 0;
        uses_rt = 0; branch = 0; ex_mr = 0; ex_rw = 0; mem_mr = 0;
        taken = 0; req = 0; ack = 0;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        step(); step();
        // load-use, then same with rd=0
        idle_in(); ex_mr = 1; ex_rd = 2; rs = 2; step();
        idle_in(); step();
        ex_mr = 1; ex_rd = 0; rs = 0; step();
        // load-to-branch with a taken branch during the stall
        idle_in(); ex_mr = 1; ex_rd = 3; rs = 3; branch = 1; step();
        taken = 1; step();
        idle_in(); step();
        // memory wait of three cycles, then immediate ack
        idle_in(); req = 1; step(); step(); step();
        ack = 1; step();
        idle_in(); step();
        req = 1; ack = 1; step();
        // memory wait arriving during the second stall cycle
        idle_in(); ex_mr = 1; ex_rd = 4; rt = 4; uses_rt = 1; branch = 1; step();
        idle_in(); req = 1; step(); step();
        ack = 1; step();
        idle_in(); step(); step();
        // ALU-to-branch and load-in-MEM-to-branch
        ex_rw = 1; ex_rd = 5; rs = 5; branch = 1; step();
        idle_in(); mem_mr = 1; mem_rd = 6; rs = 6; branch = 1; step();
        // taken branch, then reset mid-wait
        idle_in(); taken = 1; step();
        idle_in(); req = 1; step(); step();
        rst_n = 0; step();
        idle_in(); step();
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 39) != 0);
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            ex_rd   = 5'($urandom_range(0, 3));
            mem_rd  = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom);
            branch  = 1'($urandom);
            ex_mr   = ($urandom_range(0, 2) == 0);
            ex_rw   = 1'($urandom);
            mem_mr  = ($urandom_range(0, 2) == 0);
            taken   = 1'($urandom);
            req     = ($urandom_range(0, 3) == 0);
            ack     = 1'($urandom);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
